// File: rtl/fabric_ctrl_pkg.sv
// Shared types for the fabric host controller: FSM states, the buffered host word
// layout and the bit positions of the sticky error flags.
package fabric_ctrl_pkg;

  localparam int HW_DATA_W = 32;
  localparam int HW_ADDR_W = 6;
  localparam int HW_HOPS_W = 4;

  localparam int ERR_ROW = 0;
  localparam int ERR_COL = 1;
  localparam int ERR_TMO = 2;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    CALL,
    GUARD,
    WAIT,
    DONE,
    ERR
  } state_t;

  // Field widths are fixed here; the top's width parameters must keep these values.
  typedef struct packed {
    logic [HW_ADDR_W-1:0] addr;
    logic [HW_HOPS_W-1:0] col;
    logic [HW_DATA_W-1:0] data;
  } host_word_t;

endpackage

// File: rtl/fabric_ctrl_fifo.sv
// Per-row synchronous FIFO. Pointers carry an extra wrap bit; the read port is
// registered and presents zero whenever no word is popped.
module fabric_ctrl_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             rd_valid_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      rd_valid_reg <= do_pop;
      rd_data_reg  <= do_pop ? mem[rd_ptr_reg[AW-1:0]] : '0;
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;

endmodule

// File: rtl/fabric_ctrl.sv
// Host-side fabric controller: buffers host words per row, streams them onto each
// row's instruction chain, then calls the selected rows and waits for their ret.
module fabric_ctrl
  import fabric_ctrl_pkg::*;
#(
  parameter int ROWS             = 1,
  parameter int COLS             = 2,
  parameter int INSTR_DATA_WIDTH = HW_DATA_W,
  parameter int INSTR_ADDR_WIDTH = HW_ADDR_W,
  parameter int INSTR_HOPS_WIDTH = HW_HOPS_W,
  parameter int FIFO_DEPTH       = 8,
  parameter int CALL_GUARD       = 2,
  parameter int TIMEOUT_WIDTH    = 16,
  localparam int ROW_W           = $clog2(ROWS) + 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [ROW_W-1:0]                       s_row,
  input  logic [INSTR_HOPS_WIDTH-1:0]            s_col,
  input  logic [INSTR_ADDR_WIDTH-1:0]            s_addr,
  input  logic [INSTR_DATA_WIDTH-1:0]            s_data,
  input  logic                                   start,
  input  logic [ROWS-1:0]                        row_mask,
  input  logic [TIMEOUT_WIDTH-1:0]               timeout_limit,
  output logic                                   busy,
  output logic                                   done,
  output logic [2:0]                             err,
  output logic [ROWS-1:0]                        call,
  input  logic [ROWS-1:0]                        ret,
  output logic [ROWS-1:0][INSTR_DATA_WIDTH-1:0]  instr_data_out,
  output logic [ROWS-1:0][INSTR_ADDR_WIDTH-1:0]  instr_addr_out,
  output logic [ROWS-1:0][INSTR_HOPS_WIDTH-1:0]  instr_hops_out,
  output logic [ROWS-1:0]                        instr_en_out
);

  localparam int WORD_W  = $bits(host_word_t);
  localparam int GUARD_W = (CALL_GUARD > 1) ? $clog2(CALL_GUARD) : 1;

  state_t                   state_reg, state_next;
  logic [ROWS-1:0]          mask_reg;
  logic [GUARD_W-1:0]       guard_cnt_reg;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt_reg;
  logic [2:0]               err_reg;

  logic            row_ok;
  logic            col_ok;
  logic            accept;
  logic            drain_ok;
  logic [ROWS-1:0] row_hit;
  logic [ROWS-1:0] push;
  logic [ROWS-1:0] fifo_full;
  logic [ROWS-1:0] fifo_empty;
  host_word_t      in_word;

  assign row_ok  = int'(s_row) < ROWS;
  assign col_ok  = int'(s_col) < COLS;
  assign in_word = '{addr: s_addr, col: s_col, data: s_data};
  // Misaddressed words are always accepted so a bad host cannot stall the bus.
  assign s_ready = !col_ok || !(|(row_hit & fifo_full));
  assign accept  = s_valid && s_ready;

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [WORD_W-1:0] rd_bits;
      host_word_t        rd_word;

      assign row_hit[gi] = (int'(s_row) == gi);
      assign push[gi]    = accept && row_hit[gi] && col_ok;

      fabric_ctrl_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push[gi]),
        .wr_data  (in_word),
        .pop      (!fifo_empty[gi]),
        .full     (fifo_full[gi]),
        .empty    (fifo_empty[gi]),
        .rd_valid (instr_en_out[gi]),
        .rd_data  (rd_bits)
      );

      assign rd_word             = host_word_t'(rd_bits);
      assign instr_data_out[gi]  = rd_word.data;
      assign instr_addr_out[gi]  = rd_word.addr;
      assign instr_hops_out[gi]  = rd_word.col;
    end
  endgenerate

  // A masked row is quiet once its buffer is empty and its last strobe has gone.
  assign drain_ok = &(~mask_reg | (fifo_empty & ~instr_en_out));

  always_comb begin
    state_next = state_reg;
    call       = '0;
    done       = 1'b0;
    case (state_reg)
      IDLE:  if (start) state_next = DRAIN;
      DRAIN: if (drain_ok) state_next = CALL;
      CALL: begin
        call       = mask_reg;
        state_next = (CALL_GUARD == 0) ? WAIT : GUARD;
      end
      GUARD: if (guard_cnt_reg == GUARD_W'(CALL_GUARD - 1)) state_next = WAIT;
      WAIT: begin
        if ((ret & mask_reg) == mask_reg) begin
          state_next = DONE;
        end else if (timeout_limit != '0 && tmo_cnt_reg == timeout_limit) begin
          state_next = ERR;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mask_reg      <= '0;
      guard_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
      err_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        mask_reg <= row_mask;
        err_reg  <= '0;
      end else if (state_reg == WAIT && state_next == ERR) begin
        err_reg[ERR_TMO] <= 1'b1;
      end
      // Flags from this cycle's ingress win over a same-cycle clear.
      if (accept && !row_ok) err_reg[ERR_ROW] <= 1'b1;
      if (accept && !col_ok) err_reg[ERR_COL] <= 1'b1;

      guard_cnt_reg <= (state_reg == GUARD) ? guard_cnt_reg + 1'b1 : '0;
      if (state_reg != WAIT) begin
        tmo_cnt_reg <= '0;
      end else if (tmo_cnt_reg != '1) begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
    end
  end

  assign busy = (state_reg != IDLE);
  assign err  = err_reg;

endmodule
